// File: rtl/branch_update_ctrl.sv
// branch_update_ctrl: in-order queue of fetch predictions, retired at resolve to train the history table
module branch_update_ctrl #(
   parameter int IDX_W = 4,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Fetch_Valid,
   input  logic [IDX_W-1:0]         Fetch_Idx,
   input  logic                     Fetch_Predict,
   output logic                     Fetch_Ready,
   input  logic                     Resolve_Valid,
   input  logic                     Resolve_Taken,
   output logic                     Upd_EN,
   output logic [IDX_W-1:0]         Upd_Idx,
   output logic                     Upd_Branch,
   output logic                     Mispredict,
   output logic                     Underflow,
   output logic [$clog2(DEPTH):0]   Occupancy,
   output logic [15:0]              Branch_Cnt,
   output logic [15:0]              Miss_Cnt
);
   localparam int PW = $clog2(DEPTH);
   logic [IDX_W-1:0] r_idx [DEPTH];
   logic [DEPTH-1:0] r_pred;
   logic [PW-1:0]    r_wr, r_rd;
   logic [PW:0]      r_occ;
   logic             r_upd_en, r_upd_br, r_mis, r_und;
   logic [IDX_W-1:0] r_upd_idx;
   logic [15:0]      r_bcnt, r_mcnt;
   logic             w_empty, w_full, w_pop, w_miss, w_push;
   always_comb begin
      w_empty     = r_occ == '0;
      w_full      = r_occ == (PW+1)'(DEPTH);
      w_pop       = Resolve_Valid && !w_empty;
      w_miss      = w_pop && (r_pred[r_rd] != Resolve_Taken);
      // a full queue still accepts when the head retires correctly this cycle
      Fetch_Ready = !w_full || (Resolve_Valid && !w_miss);
      w_push      = Fetch_Valid && Fetch_Ready && !w_miss;
   end
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_idx[r_wr]  <= Fetch_Idx;
         r_pred[r_wr] <= Fetch_Predict;
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr      <= '0;
         r_rd      <= '0;
         r_occ     <= '0;
         r_upd_en  <= 1'b0;
         r_upd_idx <= '0;
         r_upd_br  <= 1'b0;
         r_mis     <= 1'b0;
         r_und     <= 1'b0;
         r_bcnt    <= '0;
         r_mcnt    <= '0;
      end else begin
         r_upd_en <= w_pop;
         r_mis    <= w_miss;
         r_und    <= Resolve_Valid && w_empty;
         if (w_pop) begin
            r_upd_idx <= r_idx[r_rd];
            r_upd_br  <= Resolve_Taken;
         end
         if (w_pop && r_bcnt != 16'hFFFF) r_bcnt <= r_bcnt + 16'd1;
         if (w_miss && r_mcnt != 16'hFFFF) r_mcnt <= r_mcnt + 16'd1;
         // wrong-path flush: everything younger than the head is dropped
         if (w_miss) begin
            r_rd  <= r_wr;
            r_occ <= '0;
         end else begin
            r_wr  <= r_wr + PW'(w_push);
            r_rd  <= r_rd + PW'(w_pop);
            r_occ <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
         end
      end
   end
   assign Upd_EN     = r_upd_en;
   assign Upd_Idx    = r_upd_idx;
   assign Upd_Branch = r_upd_br;
   assign Mispredict = r_mis;
   assign Underflow  = r_und;
   assign Occupancy  = r_occ;
   assign Branch_Cnt = r_bcnt;
   assign Miss_Cnt   = r_mcnt;
endmodule

// File: tb/tb_branch_update_ctrl.sv
// tb_branch_update_ctrl: vector table, corner sequences and random traffic against a queue model
module tb_branch_update_ctrl;
   localparam int IDX_W = 4;
   localparam int DEPTH = 4;
   logic CLK = 0, RST = 1, Fetch_Valid = 0, Fetch_Predict = 0, Resolve_Valid = 0, Resolve_Taken = 0;
   logic [IDX_W-1:0] Fetch_Idx = '0;
   logic Fetch_Ready, Upd_EN, Upd_Branch, Mispredict, Underflow;
   logic [IDX_W-1:0] Upd_Idx;
   logic [2:0] Occupancy;
   logic [15:0] Branch_Cnt, Miss_Cnt;

   branch_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .Fetch_Valid(Fetch_Valid), .Fetch_Idx(Fetch_Idx), .Fetch_Predict(Fetch_Predict),
      .Fetch_Ready(Fetch_Ready),
      .Resolve_Valid(Resolve_Valid), .Resolve_Taken(Resolve_Taken),
      .Upd_EN(Upd_EN), .Upd_Idx(Upd_Idx), .Upd_Branch(Upd_Branch),
      .Mispredict(Mispredict), .Underflow(Underflow), .Occupancy(Occupancy),
      .Branch_Cnt(Branch_Cnt), .Miss_Cnt(Miss_Cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;

   typedef struct {logic [IDX_W-1:0] idx; logic pred;} ent_t;
   ent_t q[$];
   logic m_upd = 0, m_br = 0, m_mis = 0, m_und = 0;
   logic [IDX_W-1:0] m_idx = '0;
   int m_bc = 0, m_mc = 0;
   logic s_rdy;

   typedef struct {int fv, fi, fp, rv, rt, rdy, upd, idx, br, mis, und, occ, bc, mc;} vec_t;
   vec_t tbl[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic m_ready(input logic rv, input logic rt);
      return q.size() < DEPTH || (rv && q.size() > 0 && q[0].pred == rt);
   endfunction

   task automatic step(input logic rst, input logic fv, input logic [IDX_W-1:0] fi,
                       input logic fp, input logic rv, input logic rt);
      logic pop, miss, push;
      @(negedge CLK);
      RST = rst; Fetch_Valid = fv; Fetch_Idx = fi; Fetch_Predict = fp;
      Resolve_Valid = rv; Resolve_Taken = rt;
      #1;
      s_rdy = Fetch_Ready;
      if (!rst) chk("ready", s_rdy, m_ready(rv, rt));
      if (rst) begin
         q.delete();
         m_bc = 0; m_mc = 0; m_upd = 0; m_idx = '0; m_br = 0; m_mis = 0; m_und = 0;
      end else begin
         pop  = rv && q.size() > 0;
         miss = pop && q[0].pred != rt;
         push = fv && m_ready(rv, rt) && !miss;
         m_upd = pop; m_mis = miss; m_und = rv && q.size() == 0;
         if (pop) begin
            m_idx = q[0].idx; m_br = rt;
            void'(q.pop_front());
            if (m_bc < 65535) m_bc++;
            if (miss && m_mc < 65535) m_mc++;
         end
         if (miss) q.delete();
         if (push) q.push_back('{fi, fp});
      end
      @(posedge CLK);
      #1;
      chk("upd_en", Upd_EN, m_upd);
      chk("upd_idx", Upd_Idx, m_idx);
      chk("upd_branch", Upd_Branch, m_br);
      chk("mispredict", Mispredict, m_mis);
      chk("underflow", Underflow, m_und);
      chk("occupancy", Occupancy, q.size());
      chk("branch_cnt", Branch_Cnt, m_bc);
      chk("miss_cnt", Miss_Cnt, m_mc);
   endtask

   initial begin
      //           fv fi fp rv rt rdy upd idx br mis und occ bc mc
      tbl[0]  = '{1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, 1, 1, 1, 3, 1, 0, 0, 0, 1, 0};
      tbl[2]  = '{1, 1, 1, 0, 0, 1, 0, 3, 1, 0, 0, 1, 1, 0};
      tbl[3]  = '{1, 2, 0, 0, 0, 1, 0, 3, 1, 0, 0, 2, 1, 0};
      tbl[4]  = '{1, 5, 0, 0, 0, 1, 0, 3, 1, 0, 0, 3, 1, 0};
      tbl[5]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 2, 1};
      tbl[6]  = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 2, 1};
      tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2, 1};
      tbl[8]  = '{1, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 2, 1};
      tbl[9]  = '{1, 7, 0, 1, 1, 1, 1, 2, 1, 1, 0, 0, 3, 2};
      tbl[10] = '{1, 9, 1, 1, 1, 1, 0, 2, 1, 0, 1, 1, 3, 2};
      tbl[11] = '{0, 0, 0, 1, 1, 1, 1, 9, 1, 0, 0, 0, 4, 2};
      tbl[12] = '{1, 10, 1, 0, 0, 1, 0, 9, 1, 0, 0, 1, 4, 2};
      tbl[13] = '{1, 11, 0, 0, 0, 1, 0, 9, 1, 0, 0, 2, 4, 2};
      tbl[14] = '{1, 12, 1, 0, 0, 1, 0, 9, 1, 0, 0, 3, 4, 2};
      tbl[15] = '{1, 13, 0, 0, 0, 1, 0, 9, 1, 0, 0, 4, 4, 2};
      tbl[16] = '{1, 14, 1, 0, 0, 0, 0, 9, 1, 0, 0, 4, 4, 2};
      tbl[17] = '{1, 14, 1, 1, 1, 1, 1, 10, 1, 0, 0, 4, 5, 2};
      tbl[18] = '{1, 15, 0, 1, 0, 1, 1, 11, 0, 0, 0, 4, 6, 2};

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("reset_occ", Occupancy, 0);
      chk("reset_upd", Upd_EN, 0);
      for (int i = 0; i < 19; i++) begin
         step(0, tbl[i].fv[0], 4'(tbl[i].fi), tbl[i].fp[0], tbl[i].rv[0], tbl[i].rt[0]);
         chk($sformatf("t%0d_rdy", i), s_rdy, tbl[i].rdy);
         chk($sformatf("t%0d_upd", i), Upd_EN, tbl[i].upd);
         chk($sformatf("t%0d_idx", i), Upd_Idx, tbl[i].idx);
         chk($sformatf("t%0d_br", i), Upd_Branch, tbl[i].br);
         chk($sformatf("t%0d_mis", i), Mispredict, tbl[i].mis);
         chk($sformatf("t%0d_und", i), Underflow, tbl[i].und);
         chk($sformatf("t%0d_occ", i), Occupancy, tbl[i].occ);
         chk($sformatf("t%0d_bc", i), Branch_Cnt, tbl[i].bc);
         chk($sformatf("t%0d_mc", i), Miss_Cnt, tbl[i].mc);
      end

      // full queue: push/pop pairs wrap the pointers, heads come out 12..15,0..3
      for (int j = 0; j < 8; j++) begin
         step(0, 1, 4'(j), ~j[0], 1, ~j[0]);
         chk("wrap_idx", Upd_Idx, (12 + j) & 15);
         chk("wrap_occ", Occupancy, 4);
         chk("wrap_bc", Branch_Cnt, 7 + j);
         chk("wrap_mis", Mispredict, 0);
      end

      // reset with three in flight and a resolve pending
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 4'd1, 1, 0, 0);
      step(0, 1, 4'd2, 1, 0, 0);
      step(0, 1, 4'd3, 1, 1, 1);
      step(0, 1, 4'd4, 1, 0, 0);
      chk("pre_rst_occ", Occupancy, 3);
      step(1, 1, 4'd6, 1, 1, 1);
      chk("rst_upd", Upd_EN, 0);
      chk("rst_occ", Occupancy, 0);
      chk("rst_bc", Branch_Cnt, 0);
      chk("rst_mc", Miss_Cnt, 0);
      chk("rst_idx", Upd_Idx, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_ready", s_rdy, 1);

      // randomized traffic, resolves biased toward the correct outcome
      for (int k = 0; k < 3000; k++) begin
         logic rt;
         rt = ($urandom % 4 != 0 && q.size() > 0) ? q[0].pred : 1'($urandom);
         step(($urandom % 50) == 0, 1'($urandom), 4'($urandom), 1'($urandom),
              1'($urandom), rt);
      end

      // counter saturation
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 4'd1, 1, 0, 0);
      for (int k = 0; k < 65534; k++) step(0, 1, 4'd1, 1, 1, 1);
      chk("sat_fffe", Branch_Cnt, 16'hFFFE);
      step(0, 1, 4'd1, 1, 1, 1);
      chk("sat_ffff_1", Branch_Cnt, 16'hFFFF);
      step(0, 1, 4'd1, 1, 1, 1);
      chk("sat_ffff_2", Branch_Cnt, 16'hFFFF);
      chk("sat_mc", Miss_Cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IDX_W  4  history-table index width
  DEPTH  4  in-flight branch queue depth, power of two, >= 2
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK  in  1  clock, all state updates on rising edge
  RST  in  1  reset, synchronous, active-high
  Fetch_Valid  in  1  a predicted branch leaves fetch this cycle
  Fetch_Idx  in  IDX_W  history-table index used for the prediction
  Fetch_Predict  in  1  prediction issued (1 = taken)
  Fetch_Ready  out  1  queue can accept a branch this cycle
  Resolve_Valid  in  1  execute resolves the oldest in-flight branch
  Resolve_Taken  in  1  actual outcome (1 = taken)
  Upd_EN  out  1  history-table update strobe (drives entry Branch_EN)
  Upd_Idx  out  IDX_W  entry to update
  Upd_Branch  out  1  outcome to train with (drives entry Branch)
  Mispredict  out  1  one-cycle pulse, prediction was wrong
  Underflow  out  1  one-cycle pulse, resolve with empty queue
  Occupancy  out  log2(DEPTH)+1  entries in flight
  Branch_Cnt  out  16  resolved branches, saturating
  Miss_Cnt  out  16  mispredicted branches, saturating

Function
REQ-003 Block SHALL hold an in-order FIFO of {Fetch_Idx, Fetch_Predict} pairs, DEPTH entries, with circular read/write pointers.
REQ-004 Fetch_Ready SHALL be combinational: 1 when Occupancy < DEPTH, or when Occupancy == DEPTH and Resolve_Valid is 1 with no mispredict at head.
REQ-005 Push SHALL occur when Fetch_Valid && Fetch_Ready; Fetch_Valid with Fetch_Ready=0 SHALL be dropped, no state change.
REQ-006 Pop SHALL occur when Resolve_Valid && Occupancy > 0; head entry removed.
REQ-007 One cycle after a pop, outputs SHALL be registered: Upd_EN=1, Upd_Idx=head Idx, Upd_Branch=Resolve_Taken, Mispredict=(head Predict != Resolve_Taken).
REQ-008 Upd_EN, Mispredict, Underflow SHALL be 0 in every cycle not following a qualifying event; Upd_Idx/Upd_Branch hold last value.
REQ-009 On a mispredicting pop, all remaining entries SHALL be discarded (wrong path): Occupancy becomes 0 next cycle, pointers equalised.
REQ-010 A push in the same cycle as a mispredicting pop SHALL be discarded.
REQ-011 A push and a correct pop in the same cycle SHALL both take effect; Occupancy unchanged.
REQ-012 Resolve_Valid with Occupancy == 0 SHALL produce Underflow=1 next cycle, no Upd_EN, no counter change; a same-cycle push still takes effect.
REQ-013 Pointers SHALL wrap modulo DEPTH; Occupancy SHALL never exceed DEPTH.
REQ-014 Branch_Cnt SHALL increment by 1 per pop; Miss_Cnt by 1 per mispredicting pop; both saturate at 16'hFFFF.
REQ-015 Counter values SHALL update in the same cycle as the corresponding Upd_EN pulse becomes visible.

Reset
REQ-016 While RST=1 at a rising edge: pointers, Occupancy, Branch_Cnt, Miss_Cnt SHALL become 0; Upd_EN, Mispredict, Underflow, Upd_Idx, Upd_Branch SHALL become 0.
REQ-017 RST SHALL take priority over simultaneous Fetch_Valid/Resolve_Valid; in-flight entries SHALL be lost, no update strobe issued for them.
REQ-018 First cycle after RST deasserts, Fetch_Ready SHALL be 1.

Verification
REQ-019 Push idx 3/pred 1, then resolve taken -> next cycle Upd_EN=1, Upd_Idx=3, Upd_Branch=1, Mispredict=0, Branch_Cnt=1, Miss_Cnt=0.
REQ-020 Push idx 1,2,5 (pred 1,0,0); resolve head not-taken -> Upd_Idx=1, Upd_Branch=0, Mispredict=1, Occupancy=0, Miss_Cnt=1; later resolve -> Underflow=1.
REQ-021 Push 4 entries -> Occupancy=4, Fetch_Ready=0; fifth push alone dropped; fifth push with correct resolve accepted, Occupancy stays 4; 8 further push/pop pairs verify wrap order.
REQ-022 Mispredicting resolve with simultaneous push idx 7 -> idx 7 never appears on Upd_Idx, Occupancy=0.
REQ-023 RST asserted with 3 in flight and Resolve_Valid=1 -> no Upd_EN, Occupancy=0, counters 0, Fetch_Ready=1 after release.
REQ-024 Preload Branch_Cnt to 16'hFFFE via 65534 correct resolves; two more -> Branch_Cnt=16'hFFFF both times.
